// File: rtl/dac_sched_pkg.sv
// Shared types and helpers for the DAC output scheduler: FSM states, grant
// encoding and the two's-complement to offset-binary conversion.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        PARK      = 2'd0,
        WAIT_TICK = 2'd1,
        PENDING   = 2'd2
    } sched_state_t;

    typedef enum logic {
        GNT_ADC = 1'b0,
        GNT_CAL = 1'b1
    } grant_t;

    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    // Flipping the sign bit maps signed -2^(w-1)..2^(w-1)-1 onto 0..2^w-1.
    function automatic logic [31:0] to_offset_bin(input logic [31:0] s, input int unsigned width);
        return s ^ midscale(width);
    endfunction

endpackage

// File: rtl/dac_slot_timer.sv
// Slot-rate divider: pulses o_tick once every i_rate_div+1 clocks while running.
// The divisor is captured at each boundary so a new rate starts with the next slot.
module dac_slot_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic [DIV_WIDTH-1:0] i_rate_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_at_end;

    assign w_at_end = (r_count == r_div);
    assign o_tick   = ~i_clr & w_at_end;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || w_at_end) begin
            r_count <= '0;
            r_div   <= i_rate_div;
        end else begin
            r_count <= r_count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dac_out_scheduler.sv
// Paced round-robin feeder sharing one DAC write port between the ADC stream
// and the calibration source; parks the DAC at midscale when disabled.
module dac_out_scheduler
    import dac_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [DIV_WIDTH-1:0]  i_rate_div,
    input  logic [DATA_WIDTH-1:0] i_adc_data,
    input  logic                  i_adc_valid,
    output logic                  o_adc_ready,
    input  logic [DATA_WIDTH-1:0] i_cal_data,
    input  logic                  i_cal_valid,
    output logic                  o_cal_ready,
    output logic [DATA_WIDTH-1:0] o_dac_data,
    output logic                  o_dac_wr,
    input  logic                  i_dac_busy,
    output logic [CNT_WIDTH-1:0]  o_underrun_cnt,
    output logic [CNT_WIDTH-1:0]  o_miss_cnt
);

    localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(midscale(DATA_WIDTH));

    sched_state_t          r_state;
    sched_state_t          w_next_state;
    grant_t                r_last_grant;
    grant_t                w_grant;
    logic                  r_park_pend;
    logic                  r_dac_wr;
    logic [DATA_WIDTH-1:0] r_dac_data;
    logic [CNT_WIDTH-1:0]  r_underrun_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic                  w_clr;
    logic                  w_tick;
    logic                  w_open;
    logic                  w_serve;
    logic                  w_any_valid;
    logic                  w_park_write;
    logic                  w_miss;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // The timer only runs once the FSM has left PARK, so the first slot
    // after enabling is a full period away.
    assign w_clr = ~i_enable | (r_state == PARK);

    dac_slot_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_clr),
        .i_rate_div (i_rate_div),
        .o_tick     (w_tick)
    );

    assign w_open       = i_enable & (((r_state == WAIT_TICK) & w_tick) | (r_state == PENDING));
    assign w_serve      = w_open & ~i_dac_busy & ~i_rst;
    assign w_any_valid  = i_adc_valid | i_cal_valid;
    assign w_park_write = (r_state == PARK) & r_park_pend & ~i_dac_busy;
    assign w_miss       = i_enable & (r_state == PENDING) & w_tick & i_dac_busy;

    always_comb begin
        w_grant = GNT_ADC;
        if (i_adc_valid && i_cal_valid) begin
            w_grant = (r_last_grant == GNT_CAL) ? GNT_ADC : GNT_CAL;
        end else if (i_cal_valid) begin
            w_grant = GNT_CAL;
        end
    end

    assign w_sel_data  = (w_grant == GNT_CAL) ? i_cal_data : i_adc_data;
    assign o_adc_ready = w_serve & i_adc_valid & (w_grant == GNT_ADC);
    assign o_cal_ready = w_serve & i_cal_valid & (w_grant == GNT_CAL);

    always_comb begin
        w_next_state = r_state;
        if (!i_enable) begin
            w_next_state = PARK;
        end else begin
            case (r_state)
                PARK:      w_next_state = WAIT_TICK;
                WAIT_TICK: if (w_tick && !w_serve) w_next_state = PENDING;
                PENDING:   if (w_serve) w_next_state = WAIT_TICK;
                default:   w_next_state = PARK;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= PARK;
            r_last_grant   <= GNT_CAL;
            r_park_pend    <= 1'b0;
            r_dac_wr       <= 1'b0;
            r_dac_data     <= MID;
            r_underrun_cnt <= '0;
            r_miss_cnt     <= '0;
        end else begin
            r_state  <= w_next_state;
            r_dac_wr <= 1'b0;

            if (w_serve && w_any_valid) begin
                r_dac_wr     <= 1'b1;
                r_dac_data   <= DATA_WIDTH'(to_offset_bin(32'(w_sel_data), DATA_WIDTH));
                r_last_grant <= w_grant;
            end else if (w_park_write) begin
                r_dac_wr   <= 1'b1;
                r_dac_data <= MID;
            end

            // A re-enable while the park write is still blocked abandons it.
            if (!i_enable && r_state != PARK) begin
                r_park_pend <= 1'b1;
            end else if (w_park_write || (i_enable && r_state == PARK)) begin
                r_park_pend <= 1'b0;
            end

            if (w_serve && !w_any_valid && r_underrun_cnt != '1) begin
                r_underrun_cnt <= r_underrun_cnt + CNT_WIDTH'(1);
            end
            if (w_miss && r_miss_cnt != '1) begin
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_dac_wr       = r_dac_wr;
    assign o_dac_data     = r_dac_data;
    assign o_underrun_cnt = r_underrun_cnt;
    assign o_miss_cnt     = r_miss_cnt;

endmodule
